// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding,
// parity mode constants, default frame shape and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned DEF_DATA_BITS   = 8;
    localparam int unsigned DEF_PARITY_MODE = PAR_NONE;
    localparam int unsigned DEF_STOP_BITS   = 1;

    // Parity over the low nbits of data; odd mode returns the inverse so the
    // total count of ones on the wire (data + parity) comes out odd.
    function automatic logic frame_parity(
        input logic [7:0]  data,
        input int unsigned nbits,
        input int unsigned mode
    );
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) begin
                p = p ^ data[i];
            end
        end
        if (mode == PAR_ODD) begin
            p = ~p;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// Tick-paced asynchronous serial transmitter: one byte per valid/ready
// handshake, sent as start, LSB-first data, optional parity and stop bits.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
    parameter int unsigned PARITY_MODE = DEF_PARITY_MODE,
    parameter int unsigned STOP_BITS   = DEF_STOP_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic       r_parity;
    logic       r_tx;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;

    tx_state_t  w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic       w_stop_cnt_nxt;
    logic       w_parity_nxt;
    logic       w_tx_nxt;
    logic       w_done_nxt;
    logic       w_handshake;

    assign w_handshake = tx_valid && r_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_done_nxt     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_shift_nxt    = tx_data;
                    w_parity_nxt   = frame_parity(tx_data, DATA_BITS, PARITY_MODE);
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = '0;
                    w_state_nxt    = ST_WAIT;
                end
            end
            // A tick coinciding with the handshake is seen from IDLE and so never
            // advances WAIT; the start bit always lands on a later tick.
            ST_WAIT: begin
                if (tick) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so tx is a plain register
    // that moves on the same edge the tick is sampled.
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_parity_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine across four frame configurations with
// tick every 4 clocks; a line decoder per instance checks frames against a model.
module tb_uart_tx_engine;
    import uart_pkg::*;

    localparam int unsigned TDIV = 4;

    typedef struct packed {
        logic [11:0] bits;
        logic [31:0] start_pe;
    } exp_t;

    logic        clk = 1'b0;
    logic        tick = 1'b0;
    int unsigned pe = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        pe++;
    end

    initial forever begin
        @(negedge clk);
        tick = ((pe + 1) % TDIV == 0);
    end

    task automatic chk(input string nm, input int unsigned inst,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=0x%0h expected=0x%0h at posedge %0d",
                     nm, inst, act, exp, pe);
        end
    endtask

    // Wire-order frame: bit 0 start, then data LSB first, optional parity;
    // everything above stays 1, which covers the stop bits.
    function automatic logic [11:0] ref_frame(input logic [7:0] b,
                                              input int unsigned db,
                                              input int unsigned pm);
        logic [11:0] f;
        int unsigned n;
        logic        ones;
        f    = '1;
        f[0] = 1'b0;
        n    = 1;
        ones = 1'b0;
        for (int unsigned k = 0; k < db; k++) begin
            f[n] = b[k];
            ones = ones ^ b[k];
            n++;
        end
        if (pm != 0) begin
            f[n] = (pm == 2) ? ~ones : ones;
        end
        return f;
    endfunction

    function automatic int unsigned next_tick(input int unsigned p);
        return (p / TDIV + 1) * TDIV;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int unsigned DB   = (gi == 3) ? 7 : 8;
        localparam int unsigned PM   = (gi == 1) ? PAR_EVEN : ((gi == 2) ? PAR_ODD : PAR_NONE);
        localparam int unsigned SB   = (gi == 3) ? 2 : 1;
        localparam int unsigned FLEN = 1 + DB + ((PM != PAR_NONE) ? 1 : 0) + SB;
        localparam logic [11:0] FMASK = 12'((1 << FLEN) - 1);
        localparam logic [7:0]  FIRST = (gi == 0) ? 8'h55 : ((gi == 3) ? 8'hFF : 8'h07);

        logic       reset;
        logic       tx_valid;
        logic [7:0] tx_data;
        logic       tx_ready;
        logic       tx;
        logic       tx_busy;
        logic       tx_done;
        exp_t       exp_q[$];
        bit         stim_done = 1'b0;

        uart_tx_engine #(
            .DATA_BITS  (DB),
            .PARITY_MODE(PM),
            .STOP_BITS  (SB)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .tx_data (tx_data),
            .tx_valid(tx_valid),
            .tx_ready(tx_ready),
            .tx      (tx),
            .tx_busy (tx_busy),
            .tx_done (tx_done)
        );

        // Called on a negedge; returns the posedge number of the handshake.
        task automatic send(input logic [7:0] b, input bit keep, output int unsigned h);
            int unsigned waited;
            waited   = 0;
            tx_data  = b;
            tx_valid = 1'b1;
            while (!tx_ready && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (!tx_ready) begin
                chk("ready_timeout", gi, 64'(tx_ready), 64'(1));
                tx_valid = 1'b0;
                h = 0;
            end else begin
                h = pe + 1;
                exp_q.push_back('{bits: ref_frame(b, DB, PM), start_pe: 32'(next_tick(h))});
                @(negedge clk);
                tx_data = 8'($urandom);
                if (!keep) tx_valid = 1'b0;
            end
        endtask

        task automatic wait_idle();
            int unsigned waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            if (exp_q.size() != 0) chk("drain_timeout", gi, 64'(exp_q.size()), 64'(0));
            @(negedge clk);
        endtask

        initial begin
            int unsigned h, h1, h2, s, guard;
            bit keep;
            reset    = 1'b1;
            tx_valid = 1'b0;
            tx_data  = '0;
            repeat (3) @(negedge clk);
            chk("reset_tx", gi, 64'(tx), 64'(1));
            chk("reset_ready", gi, 64'(tx_ready), 64'(1));
            chk("reset_busy", gi, 64'(tx_busy), 64'(0));
            chk("reset_done", gi, 64'(tx_done), 64'(0));
            reset = 1'b0;
            @(negedge clk);

            send(FIRST, 1'b0, h);
            wait_idle();

            // valid held across two frames; second accepted the cycle after done
            send(8'hA3, 1'b1, h1);
            send(8'h3C, 1'b0, h2);
            chk("b2b_accept", gi, 64'(h2), 64'(next_tick(h1) + TDIV * FLEN + 1));
            wait_idle();

            // reset in the middle of data bit 3
            send(8'($urandom), 1'b0, h);
            s = next_tick(h);
            while (pe + 1 < s + TDIV * 4 + 2) @(negedge clk);
            reset = 1'b1;
            if (exp_q.size() != 0) void'(exp_q.pop_back());
            @(posedge clk);
            #1;
            chk("midreset_tx", gi, 64'(tx), 64'(1));
            chk("midreset_ready", gi, 64'(tx_ready), 64'(1));
            chk("midreset_busy", gi, 64'(tx_busy), 64'(0));
            chk("midreset_done", gi, 64'(tx_done), 64'(0));
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            send(8'($urandom), 1'b0, h);
            wait_idle();

            // handshake on a tick edge
            guard = 0;
            while (!(tx_ready && ((pe + 1) % TDIV == 0)) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            send(8'($urandom), 1'b0, h);
            wait_idle();

            keep = 1'b0;
            for (int unsigned r = 0; r < 6; r++) begin
                if (!keep) repeat ($urandom_range(0, 12)) @(negedge clk);
                keep = (r == 5) ? 1'b0 : 1'($urandom_range(0, 1));
                send(8'($urandom), keep, h);
            end
            wait_idle();
            stim_done = 1'b1;
        end

        initial begin
            bit          in_frame;
            bit          rdy_ok;
            bit          stable;
            int unsigned n;
            logic [47:0] smp;
            logic [11:0] obs;
            exp_t        e;
            in_frame = 1'b0;
            rdy_ok   = 1'b1;
            n        = 0;
            smp      = '0;
            forever begin
                @(posedge clk);
                #1;
                if (reset) begin
                    in_frame = 1'b0;
                end else if (in_frame) begin
                    if (n < TDIV * FLEN) begin
                        smp[n] = tx;
                        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) rdy_ok = 1'b0;
                        if (tx_done !== 1'b0) chk("done_early", gi, 64'(tx_done), 64'(0));
                        n++;
                    end else begin
                        e      = exp_q[0];
                        obs    = '0;
                        stable = 1'b1;
                        for (int unsigned b = 0; b < FLEN; b++) begin
                            obs[b] = smp[TDIV * b];
                            for (int unsigned k = 1; k < TDIV; k++) begin
                                if (smp[TDIV * b + k] !== smp[TDIV * b]) stable = 1'b0;
                            end
                        end
                        chk("done_pulse", gi, 64'(tx_done), 64'(1));
                        chk("ready_at_done", gi, 64'(tx_ready), 64'(1));
                        chk("frame_bits", gi, 64'(obs), 64'(e.bits & FMASK));
                        chk("bit_width", gi, 64'(stable), 64'(1));
                        chk("busy_in_frame", gi, 64'(rdy_ok), 64'(1));
                        void'(exp_q.pop_front());
                        in_frame = 1'b0;
                    end
                end else begin
                    if (tx_done !== 1'b0) chk("stray_done", gi, 64'(tx_done), 64'(0));
                    if (tx === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", gi, 64'(exp_q.size()), 64'(1));
                        end else begin
                            chk("start_cycle", gi, 64'(pe), 64'(exp_q[0].start_pe));
                            in_frame = 1'b1;
                            smp      = '0;
                            n        = 1;
                            rdy_ok   = (tx_ready === 1'b0) && (tx_busy === 1'b1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int unsigned guard;
        guard = 0;
        while (!(g_inst[0].stim_done && g_inst[1].stim_done &&
                 g_inst[2].stim_done && g_inst[3].stim_done) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) chk("global_timeout", 0, 64'(guard), 64'(0));
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
